// File: rtl/pwm_spi_pkg.sv
// Shared frame geometry, register map and helper types for the SPI-programmable PWM bank.
package pwm_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int RW_BIT  = 15;
    localparam int CNT_W   = 5;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam addr_t ADDR_EN_OUT   = 7'h00;
    localparam addr_t ADDR_EN_PWM   = 7'h04;
    localparam addr_t ADDR_PRESCALE = 7'h08;
    localparam addr_t ADDR_DUTY     = 7'h20;

    // Bit counter milestones; the count saturates one past a full frame so overlong frames stay invalid.
    localparam cnt_t CNT_RD_ADDR = 5'd7;
    localparam cnt_t CNT_FULL    = 5'd16;
    localparam cnt_t CNT_SAT     = 5'd17;

endpackage

// File: rtl/spi_frame_if.sv
// SPI mode-0 target: input synchronisers, 16-bit frame capture, write/read strobes and CIPO shifter.
module spi_frame_if
    import pwm_spi_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_sclk,
    input  logic  i_copi,
    input  logic  i_ncs,
    output logic  o_cipo,
    output logic  o_cipo_oe,
    output logic  o_wr_stb,
    output addr_t o_wr_addr,
    output data_t o_wr_data,
    output logic  o_rd_stb,
    output addr_t o_rd_addr,
    input  data_t i_rdata,
    output logic  o_frame_err
);

    logic r_sclk_p0, r_sclk_p1, r_sclk_p2;
    logic r_ncs_p0, r_ncs_p1, r_ncs_p2;
    logic r_copi_p0, r_copi_p1;
    logic [1:0] r_fill;
    logic r_idle_seen;
    logic r_in_frame;
    cnt_t r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic r_rd_stb, r_rd_load, r_rd_act;
    addr_t r_rd_addr;
    data_t r_cipo_sh;
    logic r_cipo;
    logic r_wr_stb;
    addr_t r_wr_addr;
    data_t r_wr_data;
    logic r_frame_err;

    logic w_sclk_rise, w_sclk_fall, w_ncs_fall, w_ncs_rise, w_take_bit;
    logic [FRAME_W-1:0] w_shift_nxt;

    assign w_sclk_rise = r_sclk_p1 & ~r_sclk_p2;
    assign w_sclk_fall = ~r_sclk_p1 & r_sclk_p2;
    // A frame may only start once ncs has genuinely been seen idle after reset.
    assign w_ncs_fall  = ~r_ncs_p1 & r_ncs_p2 & r_idle_seen;
    assign w_ncs_rise  = r_ncs_p1 & ~r_ncs_p2 & r_in_frame;
    assign w_take_bit  = r_in_frame & ~r_ncs_p1 & w_sclk_rise;
    assign w_shift_nxt = {r_shift[FRAME_W-2:0], r_copi_p1};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_p0   <= 1'b0;
            r_sclk_p1   <= 1'b0;
            r_sclk_p2   <= 1'b0;
            r_ncs_p0    <= 1'b1;
            r_ncs_p1    <= 1'b1;
            r_ncs_p2    <= 1'b1;
            r_copi_p0   <= 1'b0;
            r_copi_p1   <= 1'b0;
            r_fill      <= 2'd0;
            r_idle_seen <= 1'b0;
            r_in_frame  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rd_stb    <= 1'b0;
            r_rd_load   <= 1'b0;
            r_rd_act    <= 1'b0;
            r_rd_addr   <= '0;
            r_cipo_sh   <= '0;
            r_cipo      <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sclk_p0 <= i_sclk;
            r_sclk_p1 <= r_sclk_p0;
            r_sclk_p2 <= r_sclk_p1;
            r_ncs_p0  <= i_ncs;
            r_ncs_p1  <= r_ncs_p0;
            r_ncs_p2  <= r_ncs_p1;
            r_copi_p0 <= i_copi;
            r_copi_p1 <= r_copi_p0;
            if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
            if (r_fill == 2'd2 && r_ncs_p1) r_idle_seen <= 1'b1;
            r_wr_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_stb    <= 1'b0;
            r_rd_load   <= r_rd_stb;
            if (w_ncs_fall) begin
                r_in_frame <= 1'b1;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_rd_act   <= 1'b0;
                r_cipo     <= 1'b0;
            end else if (w_ncs_rise) begin
                r_in_frame <= 1'b0;
                r_rd_act   <= 1'b0;
                r_cipo     <= 1'b0;
                if (r_bit_cnt == CNT_FULL) begin
                    if (r_shift[RW_BIT]) begin
                        r_wr_stb  <= 1'b1;
                        r_wr_addr <= r_shift[RW_BIT-1 -: ADDR_W];
                        r_wr_data <= r_shift[DATA_W-1:0];
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else if (r_in_frame) begin
                if (w_take_bit && r_bit_cnt != CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt < CNT_FULL) r_shift <= w_shift_nxt;
                    // Eighth bit just arrived: rw bit and address are complete.
                    if (r_bit_cnt == CNT_RD_ADDR && !w_shift_nxt[DATA_W-1]) begin
                        r_rd_stb  <= 1'b1;
                        r_rd_addr <= w_shift_nxt[ADDR_W-1:0];
                    end
                end
                if (r_rd_load) begin
                    r_cipo_sh <= i_rdata;
                    r_rd_act  <= 1'b1;
                end else if (r_rd_act && w_sclk_fall) begin
                    r_cipo    <= r_cipo_sh[DATA_W-1];
                    r_cipo_sh <= {r_cipo_sh[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign o_cipo      = r_cipo;
    assign o_cipo_oe   = ~r_ncs_p1;
    assign o_wr_stb    = r_wr_stb;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_rd_stb    = r_rd_stb;
    assign o_rd_addr   = r_rd_addr;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/pwm_spi_bank.sv
// SPI-programmable PWM bank: enable/duty register file, prescaler, shared period counter, shadowed duties.
module pwm_spi_bank
    import pwm_spi_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int DUTY_W = 8,
    parameter int PRE_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_copi,
    input  logic              i_ncs,
    output logic              o_cipo,
    output logic              o_cipo_oe,
    output logic [NUM_CH-1:0] o_pwm_out,
    output logic              o_frame_err
);

    localparam int NUM_BYTES = NUM_CH / 8;

    logic  w_wr_stb, w_rd_stb;
    addr_t w_wr_addr, w_rd_addr;
    data_t w_wr_data;
    data_t w_rdata_mux;
    logic  w_tick, w_wrap, w_pre_wr;

    logic [NUM_CH-1:0] r_en_out, r_en_pwm, r_pwm;
    logic [PRE_W-1:0]  r_prescale, r_pre_cnt;
    logic [DUTY_W-1:0] r_pcnt;
    logic [DUTY_W-1:0] r_duty_pend [NUM_CH];
    logic [DUTY_W-1:0] r_duty_act  [NUM_CH];
    data_t             r_rdata;

    spi_frame_if u_spi (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_copi      (i_copi),
        .i_ncs       (i_ncs),
        .o_cipo      (o_cipo),
        .o_cipo_oe   (o_cipo_oe),
        .o_wr_stb    (w_wr_stb),
        .o_wr_addr   (w_wr_addr),
        .o_wr_data   (w_wr_data),
        .o_rd_stb    (w_rd_stb),
        .o_rd_addr   (w_rd_addr),
        .i_rdata     (r_rdata),
        .o_frame_err (o_frame_err)
    );

    assign w_tick   = (r_pre_cnt == r_prescale);
    assign w_wrap   = w_tick && (&r_pcnt);
    assign w_pre_wr = w_wr_stb && (w_wr_addr == ADDR_PRESCALE);

    always_comb begin
        w_rdata_mux = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (w_rd_addr == ADDR_EN_OUT + addr_t'(k)) w_rdata_mux = r_en_out[8*k +: 8];
            if (w_rd_addr == ADDR_EN_PWM + addr_t'(k)) w_rdata_mux = r_en_pwm[8*k +: 8];
        end
        if (w_rd_addr == ADDR_PRESCALE) w_rdata_mux = data_t'(r_prescale);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_rd_addr == ADDR_DUTY + addr_t'(ch)) w_rdata_mux = data_t'(r_duty_pend[ch]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en_out   <= '0;
            r_en_pwm   <= '0;
            r_pwm      <= '0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_pcnt     <= '0;
            r_rdata    <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_duty_pend[ch] <= '0;
                r_duty_act[ch]  <= '0;
            end
        end else begin
            if (w_pre_wr || w_tick) r_pre_cnt <= '0;
            else                    r_pre_cnt <= r_pre_cnt + 1'b1;
            if (w_tick) r_pcnt <= r_pcnt + 1'b1;
            // Shadow load reads pending before any same-cycle write, deferring that write a period.
            if (w_wrap) begin
                for (int ch = 0; ch < NUM_CH; ch++) r_duty_act[ch] <= r_duty_pend[ch];
            end
            if (w_wr_stb) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (w_wr_addr == ADDR_EN_OUT + addr_t'(k)) r_en_out[8*k +: 8] <= w_wr_data;
                    if (w_wr_addr == ADDR_EN_PWM + addr_t'(k)) r_en_pwm[8*k +: 8] <= w_wr_data;
                end
                if (w_pre_wr) r_prescale <= w_wr_data[PRE_W-1:0];
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (w_wr_addr == ADDR_DUTY + addr_t'(ch)) r_duty_pend[ch] <= w_wr_data[DUTY_W-1:0];
                end
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_pwm[ch] <= r_en_out[ch] & (~r_en_pwm[ch] | (r_pcnt < r_duty_act[ch]) | (&r_duty_act[ch]));
            end
            if (w_rd_stb) r_rdata <= w_rdata_mux;
        end
    end

    assign o_pwm_out = r_pwm;

endmodule

// File: tb/tb_pwm_spi_bank.sv
// Directed bench for pwm_spi_bank: SPI frames driven bit by bit, PWM and read-back checked at clk negedge.
module tb_pwm_spi_bank;

    localparam int NUM_CH = 16;

    logic clk = 1'b0;
    logic rst, sclk, copi, ncs;
    logic cipo, cipo_oe, frame_err;
    logic [NUM_CH-1:0] pwm_out;

    int n_pass = 0;
    int n_total = 0;
    int hi_cnt, cyc_cnt, err_cnt;
    logic [7:0] rd_byte;
    logic [7:0] d;
    bit ok;

    pwm_spi_bank #(.NUM_CH(NUM_CH), .DUTY_W(8), .PRE_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sclk      (sclk),
        .i_copi      (copi),
        .i_ncs       (ncs),
        .o_cipo      (cipo),
        .o_cipo_oe   (cipo_oe),
        .o_pwm_out   (pwm_out),
        .o_frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc_cnt++;
            if (pwm_out[0]) hi_cnt++;
            if (frame_err) err_cnt++;
        end
    endtask

    task automatic send_bit(input logic b);
        copi = b;
        idle(5);
        sclk = 1'b1;
        idle(5);
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [15:0] word, input int nbits);
        logic [15:0] w;
        w = word;
        ncs = 1'b0;
        idle(4);
        for (int j = 0; j < nbits; j++) begin
            copi = w[15];
            w = w << 1;
            idle(5);
            if (j >= 8 && j < 16) rd_byte = {rd_byte[6:0], cipo};
            sclk = 1'b1;
            idle(5);
            sclk = 1'b0;
        end
        idle(4);
        ncs = 1'b1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] dat);
        frame({1'b1, a, dat}, 16);
        idle(8);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] dat);
        rd_byte = 8'h00;
        frame({1'b0, a, 8'h00}, 16);
        idle(8);
        dat = rd_byte;
    endtask

    task automatic wait_rise(input int max, output bit found);
        logic prev;
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            prev = pwm_out[0];
            idle(1);
            if (!prev && pwm_out[0]) found = 1'b1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        hi_cnt = 0; cyc_cnt = 0; err_cnt = 0;
        idle(4);
        chk("rst_pwm", 32'(pwm_out), 32'h0);
        chk("rst_cipo_oe", 32'(cipo_oe), 32'h0);
        chk("rst_cipo", 32'(cipo), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        idle(4);

        // Reset in the middle of a write frame to en_out byte 0
        err_cnt = 0;
        w = 16'h80FF;
        ncs = 1'b0;
        idle(4);
        for (int j = 0; j < 10; j++) begin
            send_bit(w[15]);
            w = w << 1;
        end
        rst = 1'b1;
        idle(2);
        chk("midrst_cipo_oe", 32'(cipo_oe), 32'h0);
        chk("midrst_pwm", 32'(pwm_out), 32'h0);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            send_bit(w[15]);
            w = w << 1;
        end
        idle(4);
        ncs = 1'b1;
        idle(8);
        chk("midrst_no_commit", 32'(pwm_out), 32'h0);
        chk("midrst_no_err", 32'(err_cnt), 32'h0);
        rd(7'h00, d); chk("rst_rd_en_out0", 32'(d), 32'h00);
        rd(7'h04, d); chk("rst_rd_en_pwm0", 32'(d), 32'h00);
        rd(7'h08, d); chk("rst_rd_prescale", 32'(d), 32'h00);
        rd(7'h20, d); chk("rst_rd_duty0", 32'(d), 32'h00);

        // Static enables: outputs forced high within 5 clk of ncs rising
        wr(7'h04, 8'h00);
        frame({1'b1, 7'h00, 8'hFF}, 16);
        idle(5);
        chk("en_low_byte", 32'(pwm_out[7:0]), 32'hFF);
        chk("en_high_byte", 32'(pwm_out[15:8]), 32'h00);
        idle(3);

        // PWM at prescale 0: 256-clk period
        wr(7'h00, 8'h01);
        wr(7'h04, 8'h01);
        wr(7'h20, 8'h80);
        idle(300);
        hi_cnt = 0; idle(256);
        chk("duty_80_high", 32'(hi_cnt), 32'd128);
        wr(7'h20, 8'h00);
        idle(300);
        hi_cnt = 0; idle(256);
        chk("duty_00_high", 32'(hi_cnt), 32'd0);
        wr(7'h20, 8'hFF);
        idle(300);
        hi_cnt = 0; idle(256);
        chk("duty_FF_high", 32'(hi_cnt), 32'd256);

        // Mid-period duty rewrite is deferred to the next period
        wr(7'h20, 8'h40);
        idle(300);
        wait_rise(600, ok);
        chk("shadow_sync", 32'(ok), 32'h1);
        hi_cnt = 1;
        wr(7'h20, 8'hC0);
        wait_rise(600, ok);
        chk("shadow_rise1", 32'(ok), 32'h1);
        chk("shadow_old_duty", 32'(hi_cnt - 1), 32'd64);
        hi_cnt = 1;
        wait_rise(600, ok);
        chk("shadow_rise2", 32'(ok), 32'h1);
        chk("shadow_new_duty", 32'(hi_cnt - 1), 32'd192);

        // Read-back
        wr(7'h21, 8'h5A);
        rd(7'h21, d); chk("rd_duty1", 32'(d), 32'h5A);
        rd(7'h7F, d); chk("rd_unmapped", 32'(d), 32'h00);
        rd(7'h00, d); chk("rd_en_out0", 32'(d), 32'h01);
        rd(7'h00, d); chk("rd_en_out0_again", 32'(d), 32'h01);
        rd(7'h21, d); chk("rd_duty1_again", 32'(d), 32'h5A);
        rd(7'h20, d); chk("rd_duty0_pending", 32'(d), 32'hC0);

        // Short frames flag an error and change nothing
        err_cnt = 0;
        frame({1'b1, 7'h21, 8'h11}, 15);
        idle(8);
        chk("ferr_15bit", 32'(err_cnt), 32'd1);
        rd(7'h21, d); chk("ferr_15bit_nochange", 32'(d), 32'h5A);
        err_cnt = 0;
        frame({1'b1, 7'h21, 8'h11}, 9);
        idle(8);
        chk("ferr_9bit", 32'(err_cnt), 32'd1);
        rd(7'h21, d); chk("ferr_9bit_nochange", 32'(d), 32'h5A);
        chk("read_no_err", 32'(err_cnt), 32'd1);

        // Prescale 3: tick every 4 clk, 1024-clk period
        wr(7'h08, 8'h03);
        rd(7'h08, d); chk("rd_prescale", 32'(d), 32'h03);
        wait_rise(3000, ok);
        wait_rise(3000, ok);
        chk("pre_sync", 32'(ok), 32'h1);
        hi_cnt = 1; cyc_cnt = 0;
        wait_rise(3000, ok);
        chk("pre_rise", 32'(ok), 32'h1);
        chk("pre_period", 32'(cyc_cnt), 32'd1024);
        chk("pre_high", 32'(hi_cnt - 1), 32'd768);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
